divider_4bit: RTL

DIVIDER_4BIT -- requirements
Module: divider_4bit

---
 rtl/divider_4bit_pkg.sv | 16 +
 rtl/subtractor_5bit.sv | 13 +
 rtl/divider_4bit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/divider_4bit_pkg.sv
// Shared constants for the restoring divider: FSM encoding, default width and
// the quotient reported on divide-by-zero.
package divider_4bit_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Truncated to WIDTH bits at the point of use, so it reads as all ones at any width.
    localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/subtractor_5bit.sv
// Trial subtractor for the divider: difference = a - b, borrow set when a < b.
module subtractor_5bit #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] difference,
    output logic         borrow
);

    assign {borrow, difference} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/divider_4bit.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first, with a
// single-cycle divide-by-zero path.
module divider_4bit
    import divider_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned REM_W = WIDTH + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [REM_W-1:0]   shifted_c;
    logic [REM_W-1:0]   diff_c;
    logic               borrow_c;

    // Partial remainder shifted left with the next dividend bit; the remainder is
    // always below the divisor, so the dropped MSB is zero.
    assign shifted_c = REM_W'({rem_q, dvd_q[WIDTH-1]});

    subtractor_5bit #(
        .W (REM_W)
    ) u_sub (
        .a          (shifted_c),
        .b          ({1'b0, dvs_q}),
        .difference (diff_c),
        .borrow     (borrow_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    dbz_d  = (n == '0);
                    if (n == '0) begin
                        state_d = DONE;
                        q_d     = WIDTH'(DBZ_QUOTIENT);
                        r_d     = m;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        dvd_d   = m;
                        dvs_d   = n;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end

            RUN: begin
                rem_d = borrow_c ? shifted_c : diff_c;
                quo_d = WIDTH'({quo_q, ~borrow_c});
                dvd_d = dvd_q << 1;
                // Last iteration publishes the result and parks the counter at zero.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    q_d     = quo_d;
                    r_d     = rem_d[WIDTH-1:0];
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign q           = q_q;
    assign r           = r_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule
